// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: fetches two operands for one decoded instruction,
// hands them to the execute unit, waits (bounded) for the result and writes it back.
module regfile_access_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [ADDR_WIDTH-1:0] src1_i,
  input  logic [ADDR_WIDTH-1:0] src2_i,
  input  logic [ADDR_WIDTH-1:0] dest_i,
  input  logic                  wb_en_i,
  output logic [ADDR_WIDTH-1:0] rreg1_o,
  output logic [ADDR_WIDTH-1:0] rreg2_o,
  input  logic [DATA_WIDTH-1:0] r1_i,
  input  logic [DATA_WIDTH-1:0] r2_i,
  output logic                  op_valid_o,
  output logic [DATA_WIDTH-1:0] op_a_o,
  output logic [DATA_WIDTH-1:0] op_b_o,
  input  logic                  res_valid_i,
  input  logic [DATA_WIDTH-1:0] res_data_i,
  output logic                  write_enable_o,
  output logic [ADDR_WIDTH-1:0] wreg_o,
  output logic [DATA_WIDTH-1:0] data_in_o,
  output logic                  timeout_err_o
);

  localparam int unsigned CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_e;

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic                  timeout_hit;
  logic                  instr_ready_q;
  logic [ADDR_WIDTH-1:0] rreg1_q;
  logic [ADDR_WIDTH-1:0] rreg2_q;
  logic [ADDR_WIDTH-1:0] dest_q;
  logic                  wb_en_q;
  logic                  op_valid_q;
  logic [DATA_WIDTH-1:0] op_a_q;
  logic [DATA_WIDTH-1:0] op_b_q;
  logic                  write_enable_q;
  logic [ADDR_WIDTH-1:0] wreg_q;
  logic [DATA_WIDTH-1:0] data_in_q;
  logic                  timeout_err_q;

  // Saturating wait counter; timeout fires on the edge where the count reaches TIMEOUT
  assign cnt_d       = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  assign timeout_hit = (cnt_d == CNT_WIDTH'(TIMEOUT));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      instr_ready_q  <= 1'b0;
      rreg1_q        <= '0;
      rreg2_q        <= '0;
      dest_q         <= '0;
      wb_en_q        <= 1'b0;
      op_valid_q     <= 1'b0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      write_enable_q <= 1'b0;
      wreg_q         <= '0;
      data_in_q      <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      op_valid_q     <= 1'b0;
      write_enable_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      unique case (state_q)
        // Ready is raised one cycle after reset or a timeout abort
        S_IDLE: begin
          if (!instr_ready_q) begin
            instr_ready_q <= 1'b1;
          end else if (instr_valid_i) begin
            rreg1_q       <= src1_i;
            rreg2_q       <= src2_i;
            dest_q        <= dest_i;
            wb_en_q       <= wb_en_i;
            instr_ready_q <= 1'b0;
            state_q       <= S_FETCH;
          end
        end
        S_FETCH: begin
          op_a_q     <= r1_i;
          op_b_q     <= r2_i;
          op_valid_q <= 1'b1;
          state_q    <= S_ISSUE;
        end
        S_ISSUE, S_WAIT: begin
          if (res_valid_i) begin
            data_in_q <= res_data_i;
            if (wb_en_q) begin
              write_enable_q <= 1'b1;
              wreg_q         <= dest_q;
              state_q        <= S_WB;
            end else begin
              instr_ready_q <= 1'b1;
              state_q       <= S_IDLE;
            end
          end else if (state_q == S_ISSUE) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end else begin
            cnt_q <= cnt_d;
            if (timeout_hit) begin
              timeout_err_q <= 1'b1;
              state_q       <= S_IDLE;
            end
          end
        end
        S_WB: begin
          instr_ready_q <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready_o  = instr_ready_q;
  assign rreg1_o        = rreg1_q;
  assign rreg2_o        = rreg2_q;
  assign op_valid_o     = op_valid_q;
  assign op_a_o         = op_a_q;
  assign op_b_o         = op_b_q;
  assign write_enable_o = write_enable_q;
  assign wreg_o         = wreg_q;
  assign data_in_o      = data_in_q;
  assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: register file and execute unit are modelled here,
// expectations come from a transaction-level timing model and a shadow register array.
module tb_regfile_access_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int          T  = 15;
  localparam logic [15:0] INIT_RF [8] = '{16'h1111, 16'h2222, 16'h0007, 16'h0FA3,
                                          16'h4444, 16'h0010, 16'h6666, 16'h7777};

  typedef struct {
    logic [2:0]  s1, s2, d;
    logic        wb;
    int          dly;
    logic [15:0] res, a, b;
    int          we, err, rdy;
    bit          hold, noise;
  } vec_t;

  logic          clk, rst, instr_valid, instr_ready, wb_en, op_valid;
  logic          res_valid, write_enable, timeout_err;
  logic [AW-1:0] src1, src2, dest, rreg1, rreg2, wreg;
  logic [DW-1:0] r1, r2, op_a, op_b, res_data, data_in;

  logic [DW-1:0] rf  [8];
  logic [DW-1:0] mrf [8];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  int            cyc_cnt = 0;
  int            errors  = 0;
  int            checks  = 0;
  vec_t          tbl [10];
  vec_t          v;
  int            last_acc;

  regfile_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .src1_i(src1), .src2_i(src2), .dest_i(dest), .wb_en_i(wb_en),
    .rreg1_o(rreg1), .rreg2_o(rreg2), .r1_i(r1), .r2_i(r2),
    .op_valid_o(op_valid), .op_a_o(op_a), .op_b_o(op_b),
    .res_valid_i(res_valid), .res_data_i(res_data),
    .write_enable_o(write_enable), .wreg_o(wreg), .data_in_o(data_in),
    .timeout_err_o(timeout_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Environment register file: preload port plus the DUT write port
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (write_enable) rf[wreg] <= data_in;
  end
  assign r1 = rf[rreg1];
  assign r2 = rf[rreg2];

  initial begin
    #500000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ctrl"}, 32'({instr_ready, op_valid, write_enable, timeout_err, rreg1, rreg2, wreg}), 0);
    chk({tag, ".ops"}, {op_a, op_b}, 0);
    chk({tag, ".data_in"}, 32'(data_in), 0);
  endtask

  function automatic vec_t mk(input int s1, s2, d, wb, dly, res, a, b, we, err, rdy, hold, noise);
    vec_t r;
    r.s1 = 3'(s1); r.s2 = 3'(s2); r.d = 3'(d); r.wb = 1'(wb); r.dly = dly;
    r.res = 16'(res); r.a = 16'(a); r.b = 16'(b);
    r.we = we; r.err = err; r.rdy = rdy; r.hold = 1'(hold); r.noise = 1'(noise);
    return r;
  endfunction

  // Timing model, cycles counted from the accept cycle (0): a result d cycles after
  // ISSUE (cycle 2) is taken while d <= T, otherwise the abort pulses in cycle 3+T
  function automatic vec_t predict(input int s1, s2, d, wb, dly, res);
    vec_t r;
    r = mk(s1, s2, d, wb, dly, res, 0, 0, -1, -1, 0, 0, 0);
    r.a = mrf[s1 % 8];
    r.b = mrf[s2 % 8];
    if (dly <= T) begin
      r.we  = (wb != 0) ? 3 + dly : -1;
      r.rdy = (wb != 0) ? 4 + dly : 3 + dly;
    end else begin
      r.err = 3 + T;
      r.rdy = 4 + T;
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t t);
    chk("accept_ready", 32'(instr_ready), 1);
    instr_valid = 1; src1 = t.s1; src2 = t.s2; dest = t.d; wb_en = t.wb;
    res_valid = 0; res_data = t.res;
    step();
    for (int c = 1; c <= t.rdy; c++) begin
      if (!t.hold) instr_valid = 0;
      chk("op_valid", 32'(op_valid), 32'(c == 2));
      chk("write_enable", 32'(write_enable), 32'(c == t.we));
      chk("timeout_err", 32'(timeout_err), 32'(c == t.err));
      chk("instr_ready", 32'(instr_ready), 32'(c == t.rdy));
      if (c == 1 || c == t.rdy) chk("read_addr", 32'({rreg1, rreg2}), 32'({t.s1, t.s2}));
      if (c == 2 || c == t.rdy) chk("operands", {op_a, op_b}, {t.a, t.b});
      if (c == t.we) chk("wb_payload", 32'({wreg, data_in}), 32'({t.d, t.res}));
      if (c < t.rdy) begin
        res_valid = (c == 2 + t.dly) || (t.noise && (c == 1 || c == t.we));
        step();
      end
    end
    instr_valid = 0;
    res_valid = 0;
    if (t.we >= 0) mrf[t.d] = t.res;
  endtask

  initial begin
    rst = 1; instr_valid = 0; src1 = 0; src2 = 0; dest = 0; wb_en = 0;
    res_valid = 0; res_data = 0; pl_en = 0; pl_addr = 0; pl_data = 0;

    // Reset then idle
    step(); chk_zero("reset_c1");
    step(); chk_zero("reset_c2");
    rst = 0;
    step(); chk("ready_after_reset", 32'(instr_ready), 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_strobes", 32'({op_valid, write_enable, timeout_err}), 0);
      chk("idle_ready", 32'(instr_ready), 1);
    end

    pl_en = 1;
    for (int i = 0; i < 8; i++) begin
      pl_addr = 3'(i); pl_data = INIT_RF[i]; mrf[i] = INIT_RF[i];
      step();
    end
    pl_en = 0;

    //          s1 s2 d wb dly res      a        b        we err rdy hold noise
    tbl[0] = mk(3, 5, 6, 1, 0,  'h0FB3, 'h0FA3, 'h0010, 3,  -1, 4,  0, 0);
    tbl[1] = mk(6, 5, 1, 0, 0,  'h1234, 'h0FB3, 'h0010, -1, -1, 3,  0, 0);
    tbl[2] = mk(1, 4, 7, 1, 4,  'hBEEF, 'h2222, 'h4444, 7,  -1, 8,  0, 0);
    tbl[3] = mk(7, 0, 3, 0, 4,  'hAAAA, 'hBEEF, 'h1111, -1, -1, 7,  0, 0);
    tbl[4] = mk(0, 1, 5, 1, 99, 'h0000, 'h1111, 'h2222, -1, 18, 19, 0, 0);
    tbl[5] = mk(5, 5, 4, 1, 1,  'h0020, 'h0010, 'h0010, 4,  -1, 5,  1, 1);
    tbl[6] = mk(4, 3, 0, 1, 15, 'h5A5A, 'h0020, 'h0FA3, 18, -1, 19, 0, 0);
    tbl[7] = mk(0, 6, 1, 1, 16, 'hDEAD, 'h5A5A, 'h0FB3, -1, 18, 19, 1, 0);
    tbl[8] = mk(2, 3, 2, 1, 0,  'h0008, 'h0007, 'h0FA3, 3,  -1, 4,  0, 0);
    tbl[9] = mk(2, 0, 0, 0, 0,  'h0000, 'h0008, 'h5A5A, -1, -1, 3,  0, 0);
    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // Reset while waiting, then a late result must not write
    chk("rstwait_ready", 32'(instr_ready), 1);
    instr_valid = 1; src1 = 1; src2 = 1; dest = 3; wb_en = 1;
    step(); instr_valid = 0;
    step(); step(); step();
    rst = 1;
    step(); chk_zero("rstwait_reset");
    rst = 0; res_valid = 1; res_data = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rstwait_no_write", 32'({op_valid, write_enable, timeout_err}), 0);
      chk("rstwait_ready", 32'(instr_ready), 1);
    end
    res_valid = 0;
    run_txn(predict(3, 1, 5, 0, 0, 0));

    // Back-to-back writes to every register
    for (int k = 0; k < 8; k++) begin
      v = predict(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), k, 1, 0,
                  int'($urandom_range(0, 65535)));
      if (k > 0) chk("b2b_interval", 32'(cyc_cnt - last_acc), 4);
      last_acc = cyc_cnt;
      run_txn(v);
    end

    // Randomized transactions against the model
    for (int k = 0; k < 40; k++) begin
      int r;
      int dly;
      r = int'($urandom_range(0, 9));
      dly = (r <= 5) ? r : (r == 6) ? T - 1 : (r == 7) ? T : (r == 8) ? T + 1 : 99;
      v = predict(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), dly,
                  int'($urandom_range(0, 65535)));
      v.hold  = 1'($urandom_range(0, 1));
      v.noise = 1'($urandom_range(0, 1));
      run_txn(v);
    end

    for (int i = 0; i < 8; i++) chk("final_regfile", 32'(rf[i]), 32'(mrf[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
